// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution on a raw pixel stream: passthrough, |Gx|, |Gy| or |Gx|+|Gy|.
// Two pipeline stages: window capture and border tagging, then arithmetic and saturation.
module conv3x3_stream #(
    parameter int PIXEL_SIZE   = 12,
    parameter int MAX_ROW_SIZE = 1280,
    parameter int CW           = $clog2(MAX_ROW_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  valid_in,
    input  logic [PIXEL_SIZE-1:0] pixel_in,
    input  logic [1:0]            mode,
    input  logic [CW-1:0]         row_len,
    output logic [PIXEL_SIZE-1:0] pixel_out,
    output logic                  valid_out,
    output logic                  sof_out
);

    localparam int SW = PIXEL_SIZE + 4;
    localparam logic signed [SW-1:0] PIX_MAX = {{4{1'b0}}, {PIXEL_SIZE{1'b1}}};

    // Frame position and per-frame control
    logic [CW-1:0]         col_q, col_d, cur_col;
    logic [1:0]            row_q, row_d, cur_row;
    logic [1:0]            mode_q, mode_d;
    logic [CW-1:0]         row_len_q, row_len_d;
    logic                  sof_hit, col_last;

    // Line buffers and 3x3 window (row 0 = oldest line, col 0 = oldest column)
    logic [PIXEL_SIZE-1:0] lb0_q [MAX_ROW_SIZE];
    logic [PIXEL_SIZE-1:0] lb1_q [MAX_ROW_SIZE];
    logic [PIXEL_SIZE-1:0] win_q [3][3];
    logic [PIXEL_SIZE-1:0] win_d [3][3];

    // Stage 1 tags travelling alongside the window
    logic                  v1_q, v1_d, sof1_q, sof1_d, bord1_q, bord1_d;
    logic [1:0]            mode1_q, mode1_d;

    // Stage 2 outputs
    logic [PIXEL_SIZE-1:0] pix_q, pix_d;
    logic                  vout_q, vout_d, sout_q, sout_d;

    logic signed [SW-1:0]  t [3][3];
    logic signed [SW-1:0]  gx, gy, ax, ay, res;

    // Position counters, control latching, window shift and stage-1 tags
    always_comb begin
        sof_hit   = sof & valid_in;
        cur_col   = sof_hit ? '0 : col_q;
        cur_row   = sof_hit ? 2'd0 : row_q;
        mode_d    = sof_hit ? mode : mode_q;
        row_len_d = sof_hit ? row_len : row_len_q;
        col_last  = (cur_col == row_len_d - CW'(1));
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        if (valid_in) begin
            col_d = col_last ? '0 : cur_col + CW'(1);
            row_d = (col_last && cur_row != 2'd2) ? cur_row + 2'd1 : cur_row;
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_q[cur_col];
            win_d[1][2] = lb0_q[cur_col];
            win_d[2][2] = pixel_in;
        end
        v1_d    = valid_in;
        sof1_d  = sof_hit;
        bord1_d = (cur_row < 2'd2) || (cur_col < CW'(2));
        mode1_d = mode_d;
    end

    // Gradient arithmetic, mode select, saturation and border gating
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                t[i][j] = $signed({4'b0000, win_q[i][j]});
            end
        end
        gx = (t[0][2] + (t[1][2] <<< 1) + t[2][2]) - (t[0][0] + (t[1][0] <<< 1) + t[2][0]);
        gy = (t[2][0] + (t[2][1] <<< 1) + t[2][2]) - (t[0][0] + (t[0][1] <<< 1) + t[0][2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mode1_q)
            2'd0:    res = t[1][1];
            2'd1:    res = ax;
            2'd2:    res = ay;
            default: res = ax + ay;
        endcase
        if (res > PIX_MAX) res = PIX_MAX;
        pix_d  = pix_q;
        if (v1_q) pix_d = bord1_q ? '0 : res[PIXEL_SIZE-1:0];
        vout_d = v1_q;
        sout_d = v1_q & sof1_q;
    end

    // Control and pipeline state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= 2'd0;
            mode_q    <= 2'd0;
            row_len_q <= CW'(MAX_ROW_SIZE);
            v1_q      <= 1'b0;
            sof1_q    <= 1'b0;
            bord1_q   <= 1'b1;
            mode1_q   <= 2'd0;
            pix_q     <= '0;
            vout_q    <= 1'b0;
            sout_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            mode_q    <= mode_d;
            row_len_q <= row_len_d;
            v1_q      <= v1_d;
            sof1_q    <= sof1_d;
            bord1_q   <= bord1_d;
            mode1_q   <= mode1_d;
            pix_q     <= pix_d;
            vout_q    <= vout_d;
            sout_q    <= sout_d;
        end
    end

    // Datapath storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (valid_in) begin
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb0_q[cur_col] <= pixel_in;
        end
    end

    assign pixel_out = pix_q;
    assign valid_out = vout_q;
    assign sof_out   = sout_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: a frame-image reference model predicts each output.
module tb_conv3x3_stream;

    localparam int P    = 12;
    localparam int MAXR = 1280;
    localparam int CW   = $clog2(MAXR + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          sof;
    logic          valid_in;
    logic [P-1:0]  pixel_in;
    logic [1:0]    mode;
    logic [CW-1:0] row_len;
    logic [P-1:0]  pixel_out;
    logic          valid_out;
    logic          sof_out;

    conv3x3_stream #(.PIXEL_SIZE(P), .MAX_ROW_SIZE(MAXR), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sof       (sof),
        .valid_in  (valid_in),
        .pixel_in  (pixel_in),
        .mode      (mode),
        .row_len   (row_len),
        .pixel_out (pixel_out),
        .valid_out (valid_out),
        .sof_out   (sof_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pix;
        bit sof;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: the frame as a 2D image, position tracked in absolute rows/cols
    int img [16][16];
    int m_r = 0, m_c = 0, m_mode = 0, m_rl = MAXR;

    function automatic int ref_pix(int r, int c, int md);
        int w [3][3];
        int gx, gy, v;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = img[r-2+i][c-2+j];
        gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
        gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        case (md)
            0:       v = w[1][1];
            1:       v = gx;
            2:       v = gy;
            default: v = gx + gy;
        endcase
        return (v > 4095) ? 4095 : v;
    endfunction

    // Drive one cycle; a valid pixel also feeds the model and the scoreboard
    task automatic send(bit v, bit s, int pix, int md, int rl);
        @(negedge clk);
        valid_in = v;
        sof      = s;
        pixel_in = P'(pix);
        mode     = 2'(md);
        row_len  = CW'(rl);
        if (v) begin
            exp_t e;
            if (s) begin
                m_r = 0; m_c = 0; m_mode = md; m_rl = rl;
            end
            img[m_r][m_c] = pix;
            e.pix = ref_pix(m_r, m_c, m_mode);
            e.sof = s;
            e.cyc = cyc + 2;
            sb.push_back(e);
            m_c++;
            if (m_c == m_rl) begin
                m_c = 0;
                if (m_r < 15) m_r++;
            end
        end
    endtask

    // Idle cycle with garbage on every qualified input
    task automatic gap();
        send(0, 1'($urandom), int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)),
             int'($urandom_range(3, 9)));
    endtask

    // kind: 0=16r+c, 1=100c, 2=cols 0,0,4095, 3=random. chg: from (1,1) on drive mode 0/row_len 8
    task automatic frame(int md, int rl, int rows, int kind, bit gaps, bit chg);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < rl; c++) begin
                int pix, umd, url;
                case (kind)
                    0:       pix = 16*r + c;
                    1:       pix = 100*c;
                    2:       pix = (c < 2) ? 0 : 4095;
                    default: pix = int'($urandom_range(0, 4095));
                endcase
                umd = md;
                url = rl;
                if (chg && (r > 1 || (r == 1 && c >= 1))) begin
                    umd = 0;
                    url = 8;
                end
                send(1, (r == 0 && c == 0), pix, umd, url);
                if (gaps) gap();
            end
        end
    endtask

    // Monitor: every DUT output must match the head of the scoreboard
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pixel_out", int'(pixel_out), e.pix);
                check("sof_out", int'(sof_out), int'(e.sof));
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b1;
        sof      = 1'b1;
        pixel_in = 12'd123;
        mode     = 2'd3;
        row_len  = CW'(4);
        repeat (3) begin
            @(negedge clk);
            check("rst_valid_out", int'(valid_out), 0);
            check("rst_sof_out", int'(sof_out), 0);
            check("rst_pixel_out", int'(pixel_out), 0);
        end
        rst      = 1'b0;
        valid_in = 1'b0;
        sof      = 1'b0;
        @(negedge clk);
        check("post_rst_valid_out", int'(valid_out), 0);
        check("post_rst_sof_out", int'(sof_out), 0);
        check("post_rst_pixel_out", int'(pixel_out), 0);

        frame(0, 4, 4, 0, 0, 0);   // passthrough: 17,18,33,34 at the interior
        frame(1, 4, 4, 1, 0, 0);   // Sobel-X ramp: 800
        frame(2, 4, 4, 1, 0, 0);   // Sobel-Y ramp: all 0
        frame(3, 3, 3, 2, 0, 0);   // saturation
        frame(1, 3, 3, 2, 0, 0);
        frame(1, 4, 4, 3, 0, 1);   // mid-frame control change ignored
        frame(0, 8, 3, 3, 0, 0);   // next sof applies mode 0 / row_len 8
        frame(0, 4, 4, 0, 1, 0);   // gapped passthrough
        frame(3, 5, 4, 3, 1, 0);
        frame(3, 4, 2, 3, 0, 0);   // resync: sof lands where (2,1) would be
        send(1, 0, int'($urandom_range(0, 4095)), 3, 4);
        frame(3, 4, 3, 3, 0, 0);
        for (int k = 0; k < 6; k++) begin
            frame(int'($urandom_range(0, 3)), int'($urandom_range(3, 9)),
                  int'($urandom_range(3, 6)), 3, 1'($urandom), 0);
        end
        repeat (6) send(0, 0, 0, 0, 4);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised successor to the single-mode convolution stage between CCD_Capture and the SDRAM write path.
- Accepts a raw 12-bit pixel stream and holds the last two rows in internal line buffers. Forms a 3x3 window and applies one of four run-time-selectable operators: passthrough, Sobel-X, Sobel-Y, gradient magnitude.
- Emits exactly one output pixel per input pixel, so downstream frame sizes (640*480 in SDRAM) stay unchanged.
- Row length is a run-time input, latched per frame.

Parameters:
- PIXEL_SIZE, 12, bit width of input and output pixels.
- MAX_ROW_SIZE, 1280, line-buffer depth; largest supported row_len.
- CW, $clog2(MAX_ROW_SIZE+1), width of the row_len port.

Ports:
- clk  input  1  pixel clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sof  input  1  start-of-frame; qualified by valid_in; marks the pixel at row 0, col 0.
- valid_in  input  1  pixel_in is valid this cycle; no backpressure.
- pixel_in  input  PIXEL_SIZE  raw pixel.
- mode  input  2  0=passthrough, 1=|Gx|, 2=|Gy|, 3=|Gx|+|Gy|.
- row_len  input  CW  pixels per row, 3..MAX_ROW_SIZE.
- pixel_out  output  PIXEL_SIZE  filtered pixel.
- valid_out  output  1  pixel_out valid.
- sof_out  output  1  asserted with the output corresponding to the sof input.

Behaviour:
- Reset: pixel_out=0, valid_out=0, sof_out=0, col=0, row=0, latched mode=0, latched row_len=MAX_ROW_SIZE. Line-buffer contents are don't-care.
- Counters:
  - col advances on each valid_in and wraps to 0 at latched row_len-1; row increments on wrap.
  - row saturates at 2; only "row>=2" matters.
- sof with valid_in:
  - That pixel is treated as col=0, row=0; counters restart from there, abandoning any partial row or frame.
  - mode and row_len are sampled into latched registers in the same cycle.
  - Changes to mode or row_len mid-frame have no effect until the next sof.
- Line buffers:
  - Two buffers, depth MAX_ROW_SIZE, indexed by col, read-before-write.
  - On each valid_in: LB1[col] <= LB0[col], LB0[col] <= pixel_in.
  - Window columns come from a 3-deep shift of {LB1 read, LB0 read, pixel_in}. Oldest row is on top; leftmost column is the oldest.
- Window: the input at (r,c) completes the window centred on (r-1,c-1). Taps are w[i][j], i = row 0..2 (top..bottom), j = col 0..2.
- Arithmetic (signed, width PIXEL_SIZE+4, no intermediate overflow):
  - Gx = (w02+2*w12+w22) - (w00+2*w10+w20).
  - Gy = (w20+2*w21+w22) - (w00+2*w01+w02).
  - mode 0 → w11; mode 1 → |Gx|; mode 2 → |Gy|; mode 3 → |Gx|+|Gy|.
  - Result saturates to 2^PIXEL_SIZE-1.
- Border: if r<2 or c<2 at input time, the output is 0 in every mode, including passthrough. It is still emitted with valid_out=1.
- Latency:
  - Fixed 2 cycles: valid_in/sof at cycle t → valid_out/sof_out at cycle t+2.
  - Gaps in valid_in propagate unchanged; there are no bubbles and no reordering.
  - valid_out=0 cycles hold pixel_out at its last value.
- Window shift registers advance only on valid_in; idle cycles do not disturb the window.
- Col-wrap: the window's column shift is not cleared at row start. Border gating (c<2) masks the stale columns.
- Reset mid-frame: pipeline valids clear the next cycle. No output is produced until the next input; rows count from 0 until a sof arrives.
- row_len outside 3..MAX_ROW_SIZE: behaviour undefined. The bench must not drive such values.

Test Plan:
- Reset: assert rst 3 cycles with valid_in=1 → valid_out=0, sof_out=0, pixel_out=0 throughout and on the first cycle after release.
- Passthrough: mode=0, row_len=4, pixel=16*row+col over 4 rows, continuous valid → 16 outputs.
  - sof_out with the first output.
  - Outputs for input (2,2),(2,3),(3,2),(3,3) equal 17,18,33,34.
  - All others 0; each output 2 cycles after its input.
- Sobel-X ramp: mode=1, row_len=4, pixel=100*col on all rows → output for (2,2) and (2,3) = 800. With mode=2 on the same frame, all outputs are 0.
- Saturation: mode=3, row_len=3, columns 0,0,4095 on 3 rows → output for (2,2)=4095 (Gx=16380 clamped); mode=1 also gives 4095.
- Mid-frame control change: start a frame with mode=1, switch mode to 0 and row_len to 8 at pixel (1,1) → the rest of the frame still uses Sobel-X and wraps at 4. The next sof applies mode 0 and row_len 8.
- Gaps and resync:
  - Insert valid_in=0 every other cycle → outputs are identical in value and order to the continuous run, each 2 cycles after its input.
  - Assert sof at (2,1) → counters restart; the next 2 rows' outputs are 0.
